event_packetizer: RTL and testbench

- Consumes the row arbiter's granted row index together with the column index of the same pixel-block event.
- Stamps each event with a free-running timestamp and packs it as {polarity, timestamp, x, y}.
- Buffers packed events in a first-word-fall-through FIFO with a valid/ready output handshake toward the readout/serializer.
- Drives full_o back upstream so the arbiter's enable_i can be throttled; counts events dropped on overflow.

---
 rtl/event_packetizer.sv | 99 +++++++++
 tb/tb_event_packetizer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/event_packetizer.sv
// rtl/event_packetizer.sv - timestamps granted pixel events and queues them in a FWFT FIFO
// Drops on overflow are counted (saturating) and flagged sticky until reset.
module event_packetizer #(
  parameter int X_WIDTH     = 4,
  parameter int Y_WIDTH     = 4,
  parameter int TS_WIDTH    = 16,
  parameter int TS_PRESCALE = 1,
  parameter int DEPTH       = 8,
  parameter int DROP_WIDTH  = 8,
  parameter int EVT_W       = 1 + TS_WIDTH + X_WIDTH + Y_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       evt_valid_i,
  input  logic [X_WIDTH-1:0]         xadd_i,
  input  logic [Y_WIDTH-1:0]         yadd_i,
  input  logic                       pol_i,
  input  logic                       ts_clear_i,
  output logic                       evt_valid_o,
  output logic [EVT_W-1:0]           evt_data_o,
  input  logic                       evt_ready_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [DROP_WIDTH-1:0]      drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;

  logic [PW-1:0]         presc_q;
  logic [TS_WIDTH-1:0]   ts_q;
  logic [EVT_W-1:0]      mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic [DROP_WIDTH-1:0] drop_q;
  logic                  ovf_q;

  logic push_req, push, pop, drop, tick;

  assign empty_o     = (level_q == '0);
  assign full_o      = (level_q == LW'(DEPTH));
  assign evt_valid_o = ~empty_o;
  assign evt_data_o  = empty_o ? '0 : mem[rd_ptr_q];
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;
  assign drop_cnt_o  = drop_q;

  assign push_req = enable_i & evt_valid_i;
  assign pop      = evt_valid_o & evt_ready_i;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push     = push_req & (~full_o | pop);
  assign drop     = push_req & full_o & ~pop;
  assign tick     = (presc_q == PW'(TS_PRESCALE - 1));

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= {pol_i, ts_q, xadd_i, yadd_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      presc_q  <= '0;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (ts_clear_i) begin
        presc_q <= '0;
        ts_q    <= '0;
      end else if (tick) begin
        presc_q <= '0;
        ts_q    <= ts_q + TS_WIDTH'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end

      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);

      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + DROP_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_event_packetizer.sv
// tb/tb_event_packetizer.sv - scoreboard bench for event_packetizer
module tb_event_packetizer;

  logic        clk = 1'b0;
  logic        reset_i, enable, evt_valid, pol, ts_clear, ready;
  logic [3:0]  xadd, yadd;
  logic        v_o, full, empty, ovf;
  logic [24:0] data_o;
  logic [3:0]  level;
  logic [7:0]  drop;

  logic        r2, ev2, pol2, clr2, rdy2;
  logic [3:0]  x2, y2;
  logic        v2, full2, empty2, ovf2;
  logic [12:0] data2;
  logic [2:0]  level2;
  logic [7:0]  drop2;

  int errors = 0;
  int checks = 0;
  logic [24:0] sb [$];
  logic [15:0] m_ts;

  always #5 clk = ~clk;

  event_packetizer dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable), .evt_valid_i(evt_valid),
    .xadd_i(xadd), .yadd_i(yadd), .pol_i(pol), .ts_clear_i(ts_clear),
    .evt_valid_o(v_o), .evt_data_o(data_o), .evt_ready_i(ready),
    .full_o(full), .empty_o(empty), .level_o(level),
    .overflow_o(ovf), .drop_cnt_o(drop)
  );

  event_packetizer #(.TS_WIDTH(4), .TS_PRESCALE(4), .DEPTH(4)) dut2 (
    .clk_i(clk), .reset_i(r2), .enable_i(1'b1), .evt_valid_i(ev2),
    .xadd_i(x2), .yadd_i(y2), .pol_i(pol2), .ts_clear_i(clr2),
    .evt_valid_o(v2), .evt_data_o(data2), .evt_ready_i(rdy2),
    .full_o(full2), .empty_o(empty2), .level_o(level2),
    .overflow_o(ovf2), .drop_cnt_o(drop2)
  );

  // Prescale 1 and no clear on the main instance: ts counts edges since reset.
  always @(posedge clk) m_ts <= !reset_i ? 16'h0 : m_ts + 16'h1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_i && v_o && ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h expected none", data_o);
      end else begin
        chk("pop_data", 64'(data_o), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cycle(input logic [3:0] x, input logic [3:0] y, input logic p,
                            input bit accept, input logic rdy);
    evt_valid = 1'b1;
    xadd = x;
    yadd = y;
    pol = p;
    ready = rdy;
    if (accept) sb.push_back({p, m_ts, x, y});
    tick_edge();
    evt_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!empty && n < 40) begin
      tick_edge();
      n++;
    end
    chk(name, 64'(empty), 64'(1));
  endtask

  int    caps [11] = '{1, 4, 5, 8, 9, 64, 65, 72, 73, 76, 77};
  int    exts [11] = '{0, 0, 1, 1, 2, 15, 0, 1, 0, 0, 1};

  initial begin
    logic [24:0] w1;
    int ci;
    reset_i = 1'b0; enable = 1'b1; evt_valid = 1'b0; pol = 1'b0; ts_clear = 1'b0;
    ready = 1'b0; xadd = '0; yadd = '0;
    r2 = 1'b0; ev2 = 1'b0; pol2 = 1'b0; clr2 = 1'b0; rdy2 = 1'b1; x2 = '0; y2 = '0;
    tick_edge();
    tick_edge();
    chk("rst_valid", 64'(v_o), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_data", 64'(data_o), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_drop", 64'(drop), 64'(0));
    reset_i = 1'b1;

    // Single event stamped at ts=7, held with ready low.
    for (int n = 0; n < 20 && m_ts != 16'h0007; n++) tick_edge();
    chk("ts_reach_7", 64'(m_ts), 64'h7);
    push_cycle(4'd3, 4'd5, 1'b1, 1'b1, 1'b0);
    w1 = {1'b1, 16'h0007, 4'd3, 4'd5};
    chk("single_valid", 64'(v_o), 64'(1));
    chk("single_level", 64'(level), 64'(1));
    for (int n = 0; n < 5; n++) begin
      chk("single_hold", 64'(data_o), 64'(w1));
      tick_edge();
    end
    ready = 1'b1;
    tick_edge();
    ready = 1'b0;
    chk("single_drained", 64'(empty), 64'(1));

    // Ten pushes into DEPTH=8 with no pops: two drops.
    for (int i = 0; i < 10; i++) begin
      push_cycle(4'(i), 4'(9 - i), i[0], i < 8, 1'b0);
      if (i == 7) chk("full_at_8", 64'(full), 64'(1));
    end
    chk("ovf_level", 64'(level), 64'(8));
    chk("ovf_drop", 64'(drop), 64'(2));
    chk("ovf_flag", 64'(ovf), 64'(1));

    // Push while full but head leaves in the same cycle.
    push_cycle(4'hA, 4'hB, 1'b1, 1'b1, 1'b1);
    ready = 1'b0;
    chk("fullpp_level", 64'(level), 64'(8));
    chk("fullpp_drop", 64'(drop), 64'(2));
    ready = 1'b1;
    wait_empty("drain_full");
    ready = 1'b0;

    // Steady push/pop at level 3 across pointer wrap.
    for (int i = 0; i < 3; i++) push_cycle(4'(i), 4'hC, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      push_cycle(4'(i), 4'(i + 7), i[1], 1'b1, 1'b1);
      chk("steady_level3", 64'(level), 64'(3));
    end
    ready = 1'b1;
    wait_empty("drain_steady");
    ready = 1'b0;
    chk("sb_empty_steady", 64'(sb.size()), 64'(0));

    // Push with enable low is neither stored nor counted.
    enable = 1'b0;
    push_cycle(4'h1, 4'h2, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    chk("disabled_level", 64'(level), 64'(0));
    chk("disabled_drop", 64'(drop), 64'(2));

    // Reset with five entries buffered.
    for (int i = 0; i < 5; i++) push_cycle(4'(i), 4'(i), 1'b1, 1'b1, 1'b0);
    chk("pre_rst_level", 64'(level), 64'(5));
    reset_i = 1'b0;
    sb.delete();
    tick_edge();
    reset_i = 1'b1;
    chk("mid_rst_empty", 64'(empty), 64'(1));
    chk("mid_rst_valid", 64'(v_o), 64'(0));
    chk("mid_rst_data", 64'(data_o), 64'(0));
    chk("mid_rst_drop", 64'(drop), 64'(0));
    chk("mid_rst_ovf", 64'(ovf), 64'(0));

    // Prescale-4, 4-bit timestamp: stepping, wrap and clear on a tick edge.
    tick_edge();
    r2 = 1'b1;
    ci = 0;
    for (int k = 1; k <= 77; k++) begin
      ev2 = (ci < 11) && (caps[ci] == k);
      clr2 = (k == 72);
      x2 = 4'(k);
      y2 = ~4'(k);
      pol2 = 1'b1;
      tick_edge();
      if (ev2) begin
        chk("ts_valid2", 64'(v2), 64'(1));
        chk($sformatf("ts_edge%0d", k), 64'(data2),
            64'({1'b1, 4'(exts[ci]), 4'(k), ~4'(k)}));
        ci++;
      end
      ev2 = 1'b0;
      clr2 = 1'b0;
    end

    chk("sb_empty_end", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
